// File: rtl/entropy_collector_if.sv
// Valid/ready word channel from the raw entropy source into the collector.
interface entropy_collector_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic              ent_valid;
  logic [WORD_W-1:0] ent_data;
  logic              ent_ready;

  modport master (output ent_valid, output ent_data, input ent_ready);
  modport slave  (input ent_valid, input ent_data, output ent_ready);
endinterface

// File: rtl/entropy_collector.sv
// Assembles NUM_WORDS source words into a CTR_DRBG seed, runs a repetition-count
// health test on arrival, and holds the seed until the instantiate stage is done.
module entropy_collector #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned NUM_WORDS  = 12,
  parameter int unsigned RCT_CUTOFF = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_req,
  input  logic                        i_consumer_done,
  input  logic                        i_clear_fail,
  entropy_collector_if.slave          ent_if,
  output logic [WORD_W*NUM_WORDS-1:0] o_entropy_input,
  output logic                        o_seed_start,
  output logic                        o_busy,
  output logic                        o_health_fail
);

  localparam int unsigned SEED_W = WORD_W * NUM_WORDS;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_IDX = 4'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CUTOFF   = 4'(RCT_CUTOFF);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [SEED_W-1:0] r_entropy;
  logic [WORD_W-1:0] r_last_word;
  logic              r_last_vld;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_rep_cnt;

  logic              w_accept;
  logic [CNT_W-1:0]  w_rep_nxt;
  logic              w_trip;
  logic              w_last_word;

  // Health test evaluated on the word being accepted this cycle.
  always_comb begin
    w_accept    = (r_state == S_COLLECT) && ent_if.ent_valid;
    w_rep_nxt   = 4'd1;
    if (r_last_vld && (ent_if.ent_data == r_last_word)) begin
      w_rep_nxt = (r_rep_cnt == CNT_MAX) ? CNT_MAX : r_rep_cnt + 4'd1;
    end
    w_trip      = (w_rep_nxt == CUTOFF);
    w_last_word = (r_word_cnt == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_req) w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (w_accept) begin
          if (w_trip)           w_state_nxt = S_FAIL;
          else if (w_last_word) w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:   w_state_nxt = S_WAIT;
      S_WAIT:    if (i_consumer_done) w_state_nxt = S_IDLE;
      S_FAIL:    if (i_clear_fail) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Seed shift register, health-test history and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entropy   <= '0;
      r_last_word <= '0;
      r_last_vld  <= 1'b0;
      r_word_cnt  <= '0;
      r_rep_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_word_cnt <= '0;
            r_rep_cnt  <= '0;
            r_last_vld <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_last_word <= ent_if.ent_data;
            r_last_vld  <= 1'b1;
            r_rep_cnt   <= w_rep_nxt;
            r_word_cnt  <= r_word_cnt + 4'd1;
            if (w_trip) r_entropy <= '0;
            else        r_entropy <= {r_entropy[SEED_W-WORD_W-1:0], ent_if.ent_data};
          end
        end
        S_WAIT: begin
          if (i_consumer_done) begin
            r_entropy   <= '0;
            r_last_word <= '0;
            r_last_vld  <= 1'b0;
            r_word_cnt  <= '0;
            r_rep_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ent_if.ent_ready = (r_state == S_COLLECT);
  assign o_seed_start     = (r_state == S_ISSUE);
  assign o_busy           = (r_state == S_COLLECT) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_health_fail    = (r_state == S_FAIL);
  assign o_entropy_input  = r_entropy;

endmodule
